// File: rtl/sar_adc_pkg.sv
// Shared types and defaults for the successive-approximation ADC controller.
package sar_adc_pkg;

  localparam int SAR_N_BITS_DEF        = 8;
  localparam int SAR_SAMPLE_CYCLES_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SAMPLE,
    ST_CONVERT,
    ST_DONE
  } sar_state_e;

endpackage

// File: rtl/sar_bit_sel.sv
// One-hot trial-bit selector: loaded with the MSB, walks toward the LSB one
// position per trial; its bit 0 marks the final trial.
module sar_bit_sel #(
  parameter int N_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              shift,
  output logic [N_BITS-1:0] sel,
  output logic              last
);

  localparam logic [N_BITS-1:0] MSB_ONEHOT = {1'b1, {(N_BITS-1){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel <= '0;
    end else if (load) begin
      sel <= MSB_ONEHOT;
    end else if (shift) begin
      sel <= sel >> 1;
    end
  end

  assign last = sel[0];

endmodule

// File: rtl/sar_adc_ctrl.sv
// SAR conversion controller: sample phase, then one binary-search decision per
// clock MSB first, ending in a registered result and a one-cycle done pulse.
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int N_BITS        = SAR_N_BITS_DEF,
  parameter int SAMPLE_CYCLES = SAR_SAMPLE_CYCLES_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              cmp_i,
  output logic              sample_o,
  output logic [N_BITS-1:0] dac_code_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [N_BITS-1:0] data_o
);

  localparam int                CNT_W      = $clog2(SAMPLE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST   = CNT_W'(SAMPLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_FIRST  = CNT_W'(1);
  localparam logic [N_BITS-1:0] MSB_ONEHOT = {1'b1, {(N_BITS-1){1'b0}}};

  sar_state_e        state;
  logic [CNT_W-1:0]  cnt;
  logic [N_BITS-1:0] decided;
  logic [N_BITS-1:0] next_decided;
  logic [N_BITS-1:0] sel;
  logic              last;
  logic              load;
  logic              shift;

  assign load  = (state == ST_SAMPLE) && (cnt == CNT_LAST);
  assign shift = (state == ST_CONVERT);

  // The comparator decides the bit currently on trial; all other bits keep.
  assign next_decided = cmp_i ? (decided | sel) : decided;

  sar_bit_sel #(
    .N_BITS(N_BITS)
  ) u_bit_sel (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .load (load),
    .shift(shift),
    .sel  (sel),
    .last (last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      decided    <= '0;
      sample_o   <= 1'b0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      dac_code_o <= '0;
      data_o     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          dac_code_o <= '0;
          done_o     <= 1'b0;
          if (start_i) begin
            state    <= ST_SAMPLE;
            sample_o <= 1'b1;
            busy_o   <= 1'b1;
            cnt      <= CNT_FIRST;
            decided  <= '0;
          end
        end
        ST_SAMPLE: begin
          if (cnt == CNT_LAST) begin
            state      <= ST_CONVERT;
            sample_o   <= 1'b0;
            dac_code_o <= MSB_ONEHOT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CONVERT: begin
          decided <= next_decided;
          if (last) begin
            state      <= ST_DONE;
            busy_o     <= 1'b0;
            done_o     <= 1'b1;
            dac_code_o <= next_decided;
            data_o     <= next_decided;
          end else begin
            // Next trial presents the decided bits plus the next lower bit.
            dac_code_o <= next_decided | (sel >> 1);
          end
        end
        ST_DONE: begin
          state      <= ST_IDLE;
          done_o     <= 1'b0;
          dac_code_o <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Successive-approximation control logic that consumes the decision bit of the RNM comparator (its `c_o`) and drives the DAC trial code that forms the comparator's `n_i` reference. One conversion is a fixed sample phase followed by one binary-search bit per clock, MSB first. The final code is presented on a registered result port with a one-cycle done pulse. The block sits directly downstream of the comparator in the ADC loop, and its DAC code closes the loop back to the comparator.

## Interface
- `N_BITS`, 8: resolution; width of the DAC code and the result.
- `SAMPLE_CYCLES`, 2: clocks `sample_o` is held high before bit trials start; legal range 1 to 15.
- `clk_i` input 1: the single clock; rising edge is active.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `start_i` input 1: conversion request, sampled only in IDLE.
- `cmp_i` input 1: comparator decision, synchronous to `clk_i`; 1 means the input is at or above the current DAC code.
- `sample_o` output 1: track/hold control, high during SAMPLE.
- `dac_code_o` output `N_BITS`: current DAC trial code, registered.
- `busy_o` output 1: high in SAMPLE and CONVERT.
- `done_o` output 1: one-cycle pulse in DONE.
- `data_o` output `N_BITS`: last conversion result, held until the next DONE.

## Operation
- FSM states: IDLE, SAMPLE, CONVERT, DONE.
- IDLE -> SAMPLE on a clock edge with `start_i`=1.
- SAMPLE lasts exactly `SAMPLE_CYCLES` clocks, then goes to CONVERT.
- CONVERT lasts exactly `N_BITS` clocks, then goes to DONE.
- DONE lasts 1 clock, then always returns to IDLE.
- SAMPLE: `sample_o`=1 and `dac_code_o`=0.
- CONVERT, trial k (k = 0..N_BITS-1): `dac_code_o` = bits already decided, OR-ed with trial bit `N_BITS-1-k`; all lower bits are 0.
- At the edge ending trial k, `cmp_i` is sampled. `cmp_i`=1 keeps the trial bit; `cmp_i`=0 clears it.
- DONE: `data_o` takes the final decided code on entry. `done_o`=1 and `dac_code_o` holds the final code.
- IDLE: `dac_code_o` returns to 0.
- `start_i` during SAMPLE, CONVERT or DONE is ignored; there is no queueing.
- `start_i` held high continuously starts a new conversion on the first IDLE cycle.
- Reset mid-conversion aborts immediately. The partial code is discarded and `data_o` is cleared.
- Reset values: state IDLE; `sample_o`, `busy_o` and `done_o` are 0; `dac_code_o` and `data_o` are all zeros.
- Extremes: `cmp_i` stuck at 1 gives all ones; `cmp_i` stuck at 0 gives all zeros. No overflow is possible because the code width equals `N_BITS`.

## Timing
- `start_i` is seen at edge E0.
- SAMPLE occupies cycles E0+1 .. E0+`SAMPLE_CYCLES`.
- Trial k occupies cycle E0+`SAMPLE_CYCLES`+1+k.
- `done_o` is high in cycle E0+`SAMPLE_CYCLES`+`N_BITS`+1. That is 11 cycles after E0 with the default parameters.
- `data_o` is valid from that same cycle onward.
- Minimum start-to-start period is `SAMPLE_CYCLES`+`N_BITS`+2 clocks, which includes one IDLE cycle.
- `cmp_i` must be stable for the comparator's clocking-block input skew before each edge. There is no internal synchronizer, so decision latency is 0 cycles beyond the trial cycle.
- All outputs come directly from flops; there are no combinational paths from inputs to outputs.

## Structure
- `sar_adc_pkg` holds:
  - the state enum `sar_state_e`;
  - default constants `SAR_N_BITS_DEF` and `SAR_SAMPLE_CYCLES_DEF`.
- Sub-module `sar_bit_sel`:
  - one-hot `N_BITS` shift register;
  - loaded with the MSB one-hot on CONVERT entry, shifted right each trial;
  - its last bit flags the final trial.
- The top level holds the FSM, the sample counter (width `$clog2(SAMPLE_CYCLES+1)`), and the decided-bits and `data_o` registers.
- The paired UVC interface adds `start_i`, `dac_code_o`, `busy_o`, `done_o` and `data_o` to the driver and monitor clocking blocks.

## Test plan
All cases use `N_BITS`=8 and `SAMPLE_CYCLES`=2. The bench model drives `cmp_i` = (target >= `dac_code_o`).
- Target 0xA5, single start:
  - trial codes must be 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5;
  - `done_o` pulses 11 cycles after the start edge with `data_o`=0xA5.
- Targets 0xFF and 0x00:
  - `data_o` is 0xFF and 0x00 respectively;
  - the first trial code is 0x80 in both cases.
- `start_i` held high for 30 cycles, target 0x3C:
  - back-to-back conversions run with a 12-cycle period;
  - extra starts are ignored;
  - every `done_o` shows 0x3C.
- Reset asserted in trial 4:
  - on the asynchronous edge, all outputs go to zero and the state goes to IDLE;
  - after release, a start with target 0x5A yields 0x5A with nominal latency.
- After reset, no start:
  - `sample_o`, `busy_o` and `done_o` stay 0;
  - `dac_code_o` and `data_o` stay 0x00 for 100 cycles regardless of `cmp_i` toggling.
